var_delay: RTL and testbench
============================

# var_delay

Runtime-programmable delay line: delays an N-bit sample stream by `delay_sel` clock-enable cycles, from 0 to MAX_DELAY. It replaces chains of fixed-length `delay` instances wherever the latency to be matched is only known at run time, e.g. aligning a side-band stream against a processing path whose latency is configurable. Storage is a circular buffer with one write pointer and one read pointer. A fill tracker drives `ovalid`, which marks when `odata` carries real delayed samples rather than reset filler.

## Interface
- N, 8, sample width in bits
- MAX_DELAY, 16, largest supported delay in CE cycles (≥1)
- DW, $clog2(MAX_DELAY+1), width of `delay_sel`
- master_clk  in  1  single clock, all logic on rising edge
- master_rst  in  1  synchronous, active-high reset; has priority over master_ce
- master_ce  in  1  clock enable; one sample is accepted per rising edge with master_ce=1 (a "CE edge")
- idata  in  N  input sample
- delay_sel  in  DW  requested delay in CE edges; values >MAX_DELAY clamp to MAX_DELAY
- odata  out  N  delayed sample
- ovalid  out  1  odata holds a real sample, not reset or flush filler

## Operation
- Internal state: delay_q (active delay), ring buffer, write pointer, fill counter.
- Fill counter range: 0..MAX_DELAY. It saturates at MAX_DELAY.
- delay_q update:
  - During reset: delay_q <= clamp(delay_sel).
  - On a CE edge where clamp(delay_sel) ≠ delay_q: delay_q <= clamp(delay_sel), and a flush starts.
- Flush:
  - Fill counter clears to 0.
  - odata is forced to 0 and ovalid to 0 until refill completes.
  - Buffer contents are not cleared; they are masked by the fill count.
  - The sample accepted on the flush edge counts as the first sample under the new delay.
- Reference behaviour, delay d ≥ 1:
  - Let s_k be idata at the k-th CE edge since the last reset or flush.
  - After the m-th CE edge: odata = s_(m−d+1) and ovalid = 1 if m ≥ d.
  - Otherwise odata = 0 and ovalid = 0.
  - This is identical to a chain of d enabled registers that was cleared at reset or flush.
- Delay d = 0:
  - odata = idata combinationally and ovalid = 1, except during reset cycles, when odata = 0 and ovalid = 0.
  - The fill counter is irrelevant at d = 0.
- Cycles with master_ce = 0: all state and outputs hold. delay_sel changes are ignored until the next CE edge.
- Pointer arithmetic:
  - The write pointer wraps modulo the buffer depth; no overflow condition exists.
  - The read address is derived from the write pointer minus (delay_q − 1), modulo depth.
  - For d = 1 the registered output takes the current idata directly.

## Timing
- Reset values, applied on the first rising edge with master_rst=1 and held while it stays high: odata=0, ovalid=0, write pointer=0, fill=0.
- Latency is d CE edges for d ≥ 1. odata is registered and updates only on CE edges.
- Latency is 0 for d = 0 (combinational path from idata to odata).
- ovalid for d ≥ 1:
  - Rises together with the first valid odata, on the d-th CE edge after reset or flush.
  - Stays high until the next reset or flush.
- Simultaneous master_rst and master_ce: reset wins and the sample is dropped.
- Reset mid-stream: the in-flight history is discarded. The output sequence restarts per the reference behaviour.
- Delay change of 0 → d: odata drops to 0 and becomes registered on that CE edge. ovalid falls.
- Delay change of d → 0: on that CE edge, odata switches to passthrough and ovalid = 1 immediately.

## Test plan
- d=0, idata ramp 1,2,3…, ce=1 → odata equals idata in the same cycle, ovalid=1 after reset deasserts.
- d=3, ramp starting at 1, ce=1 every cycle:
  - Edges 1–2 → odata=0, ovalid=0.
  - Edge 3 → odata=1, ovalid=1.
  - Edge 4 → odata=2.
- d=3 with ce toggling 1,0,1,0… → odata advances only on CE edges. Values match the ce=1 case indexed by CE-edge count. Outputs are stable in ce=0 cycles.
- d=3 steady stream, then delay_sel=5 at CE edge e (sample value v accepted there):
  - odata=0 and ovalid=0 for edges e..e+3.
  - At edge e+4: odata=v, ovalid=1.
- delay_sel=20 with MAX_DELAY=16 → behaves as d=16: first odata=1 at the 16th CE edge.
- d=4 streaming, master_rst pulsed for 1 cycle with ce=1 → next cycle odata=0, ovalid=0. First valid sample is the one taken on the first CE edge after reset, appearing 4 CE edges later.

Source files
------------

// File: rtl/var_delay.sv
// var_delay: runtime-programmable delay line built on a circular buffer.
// The active delay is latched from delay_sel during reset and on any CE edge
// where the clamped request differs from the current one (a flush). A fill
// counter masks stale buffer contents until enough samples have been accepted
// under the current delay. Delay 0 is a combinational passthrough.
module var_delay #(
    parameter int N         = 8,
    parameter int MAX_DELAY = 16,
    parameter int DW        = $clog2(MAX_DELAY + 1)
) (
    input  logic          master_clk,
    input  logic          master_rst,
    input  logic          master_ce,
    input  logic [N-1:0]  idata,
    input  logic [DW-1:0] delay_sel,
    output logic [N-1:0]  odata,
    output logic          ovalid
);

    // The buffer only needs to hold the d-1 samples preceding the current one.
    localparam int DEPTH = MAX_DELAY;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = AW + 1;
    localparam logic [DW-1:0] MAX_D   = DW'(MAX_DELAY);
    localparam logic [AW-1:0] LAST_WA = AW'(DEPTH - 1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [N-1:0]  mem_q [DEPTH];

    logic [DW-1:0] delay_q, delay_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [N-1:0]  odata_q;
    logic          ovalid_q;

    logic [DW-1:0] sel_clamped;
    logic          flush;
    logic [PW-1:0] wr_ext;
    logic [PW-1:0] off_ext;
    logic [PW-1:0] rd_sum;
    logic [AW-1:0] rd_addr;
    logic          out_valid_d;
    logic [N-1:0]  rd_value;

    // Next-state logic: clamp the request, detect a flush, advance pointer
    // and fill count, and pick the sample that becomes the registered output.
    always_comb begin
        sel_clamped = (delay_sel > MAX_D) ? MAX_D : delay_sel;
        flush       = master_ce && (sel_clamped != delay_q);
        delay_d     = master_ce ? sel_clamped : delay_q;

        wr_ptr_d = (wr_ptr_q == LAST_WA) ? '0 : wr_ptr_q + AW'(1);

        // The sample taken on the flush edge is the first one under the new delay.
        if (flush) begin
            fill_d = DW'(1);
        end else if (fill_q == MAX_D) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_q + DW'(1);
        end

        // Read address = write pointer - (d - 1), modulo depth. The offset is
        // meaningless for d = 0 but is never used in that case.
        wr_ext  = PW'(wr_ptr_q);
        off_ext = PW'(delay_d - DW'(1));
        if (wr_ext >= off_ext) begin
            rd_sum = wr_ext - off_ext;
        end else begin
            rd_sum = wr_ext + DEPTH_P - off_ext;
        end
        rd_addr = AW'(rd_sum);

        out_valid_d = (delay_d != '0) && (fill_d >= delay_d);
        rd_value    = (delay_d == DW'(1)) ? idata : mem_q[rd_addr];
    end

    // Sample storage: one write per accepted sample, no reset so it maps to RAM.
    always_ff @(posedge master_clk) begin
        if (master_ce && !master_rst) begin
            mem_q[wr_ptr_q] <= idata;
        end
    end

    // Control state and registered output; reset wins over the clock enable.
    always_ff @(posedge master_clk) begin
        if (master_rst) begin
            delay_q  <= sel_clamped;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
        end else if (master_ce) begin
            delay_q  <= delay_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            odata_q  <= out_valid_d ? rd_value : '0;
            ovalid_q <= out_valid_d;
        end
    end

    // Output mux: passthrough at delay 0 (blanked while reset is asserted),
    // otherwise the registered delayed sample.
    always_comb begin
        if (delay_q == '0) begin
            odata  = master_rst ? '0 : idata;
            ovalid = !master_rst;
        end else begin
            odata  = odata_q;
            ovalid = ovalid_q;
        end
    end

endmodule

// File: tb/tb_var_delay.sv
// Testbench for var_delay: directed phases from the test plan plus a random
// phase, all compared against a queue-based model of the delay definition.
module tb_var_delay;

    localparam int N         = 8;
    localparam int MAX_DELAY = 16;
    localparam int DW        = $clog2(MAX_DELAY + 1);

    logic          clk;
    logic          rst;
    logic          ce;
    logic [N-1:0]  idata;
    logic [DW-1:0] sel;
    logic [N-1:0]  odata;
    logic          ovalid;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cycle  = 0;

    // Model: samples accepted since the last reset/flush, newest at the back.
    logic [N-1:0] hist[$];
    int           md;
    int           m;
    logic [N-1:0] exp_reg;
    bit           exp_val;

    var_delay #(.N(N), .MAX_DELAY(MAX_DELAY)) dut (
        .master_clk (clk),
        .master_rst (rst),
        .master_ce  (ce),
        .idata      (idata),
        .delay_sel  (sel),
        .odata      (odata),
        .ovalid     (ovalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n_cycle, obs, exp);
        end
    endtask

    function automatic int clampf(input int s);
        return (s > MAX_DELAY) ? MAX_DELAY : s;
    endfunction

    // One clock cycle: apply inputs, update the model at the edge, compare.
    task automatic cycle(input bit r, input bit c, input int s, input logic [N-1:0] dv);
        logic [N-1:0] e_data;
        bit           e_val;
        rst   = r;
        ce    = c;
        sel   = DW'(s);
        idata = dv;
        @(posedge clk);
        n_cycle++;
        if (r) begin
            md = clampf(s);
            hist.delete();
            m = 0;
            exp_reg = '0;
            exp_val = 1'b0;
        end else if (c) begin
            if (clampf(s) != md) begin
                md = clampf(s);
                hist.delete();
                m = 0;
                exp_reg = '0;
                exp_val = 1'b0;
            end
            hist.push_back(dv);
            m++;
            if (hist.size() > 40) void'(hist.pop_front());
            if (md >= 1) begin
                if (m >= md) begin
                    exp_reg = hist[hist.size() - md];
                    exp_val = 1'b1;
                end else begin
                    exp_reg = '0;
                    exp_val = 1'b0;
                end
            end
        end
        #1;
        e_data = (md == 0) ? (r ? '0 : dv) : exp_reg;
        e_val  = (md == 0) ? !r : exp_val;
        check("odata", 32'(odata), 32'(e_data));
        check("ovalid", 32'(ovalid), 32'(e_val));
        $display("cyc %0d rst=%0b ce=%0b sel=%0d in=%02h -> out=%02h v=%0b (exp %02h/%0b)",
                 n_cycle, r, c, s, dv, odata, ovalid, e_data, e_val);
    endtask

    initial begin
        md = 0; m = 0; exp_reg = '0; exp_val = 1'b0;

        // d = 0 passthrough with a ramp
        cycle(1, 1, 0, 8'h00);
        cycle(1, 0, 0, 8'h00);
        for (int i = 1; i <= 8; i++) cycle(0, 1, 0, 8'(i));

        // d = 3 ramp, continuous CE
        cycle(1, 1, 3, 8'h00);
        for (int i = 1; i <= 12; i++) cycle(0, 1, 3, 8'(i));

        // d = 3 with CE toggling
        cycle(1, 0, 3, 8'h00);
        for (int i = 1; i <= 16; i++) cycle(0, i[0], 3, 8'($urandom));

        // steady d = 3 stream, then switch to 5
        for (int i = 0; i < 6; i++) cycle(0, 1, 3, 8'($urandom));
        for (int i = 0; i < 10; i++) cycle(0, 1, 5, 8'($urandom));

        // 0 -> d and d -> 0 transitions
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'($urandom));
        for (int i = 0; i < 8; i++) cycle(0, 1, 2, 8'($urandom));
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'($urandom));

        // clamped request: 20 behaves as 16
        cycle(1, 1, 20, 8'h00);
        for (int i = 1; i <= 22; i++) cycle(0, 1, 20, 8'(i));

        // d = 4 streaming with a one-cycle reset pulse carrying CE
        cycle(1, 1, 4, 8'h00);
        for (int i = 0; i < 7; i++) cycle(0, 1, 4, 8'($urandom));
        cycle(1, 1, 4, 8'($urandom));
        for (int i = 0; i < 8; i++) cycle(0, 1, 4, 8'($urandom));

        // random: sparse CE, occasional delay changes and resets
        begin
            int s_cur = 6;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 19) == 0) s_cur = $urandom_range(0, 31);
                cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                      s_cur, 8'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
